// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I integer core.
// Fetch, decode, execute, memory access and write-back all complete in one
// clock. The core contains a 1024-word instruction memory, a 1024-word data
// memory, a 32x32 register file and an ALU.
//
// Ports:
//   clk    - single clock; all state updates on the rising edge
//   reset  - synchronous, active-high; forces PC to 0 and blocks all writes
//
// Observation points: pc, pc_in, instruction_mux_out, mux_a_out, mux_b_out,
// alu_out, register_file.regFile, insn_memory.mem, data_memory.mem.
module rv32i_core (
  input  logic clk,
  input  logic reset
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  // funct7[5] only selects SUB (register form) and SRA/SRAI.
  function automatic alu_op_t decode_alu(logic [2:0] f3, logic f7b5, logic is_reg);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic [31:0]        res;
    a_s = a;
    b_s = b;
    case (op)
      ALU_ADD:   res = a + b;
      ALU_SUB:   res = a - b;
      ALU_SLL:   res = a << b[4:0];
      ALU_SLT:   res = {31'd0, (a_s < b_s)};
      ALU_SLTU:  res = {31'd0, (a < b)};
      ALU_XOR:   res = a ^ b;
      ALU_SRL:   res = a >> b[4:0];
      ALU_SRA:   res = $unsigned(a_s >>> b[4:0]);
      ALU_OR:    res = a | b;
      ALU_AND:   res = a & b;
      default:   res = b;
    endcase
    return res;
  endfunction

  logic [31:0] pc;
  logic [31:0] pc_in;
  logic [31:0] pc_plus4;
  logic [31:0] instruction;
  logic [31:0] instruction_mux_out;
  logic [31:0] mux_a_out;
  logic [31:0] mux_b_out;
  logic [31:0] alu_out;

  logic [6:0]  opcode;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic signed [31:0] rs1_s, rs2_s;
  logic [31:0] load_data;
  logic [31:0] wb_data;
  logic        reg_we, mem_we, br_taken;
  alu_op_t     alu_sel;

  // Fetch ignores pc[1:0]; the index wraps modulo 1024 words.
  rv32i_imem insn_memory (
    .clk   (clk),
    .we    (1'b0),
    .waddr (10'd0),
    .wdata (32'd0),
    .raddr (pc[11:2]),
    .rdata (instruction)
  );

  assign instruction_mux_out = reset ? NOP_WORD : instruction;

  assign opcode    = instruction_mux_out[6:0];
  assign rd_addr   = instruction_mux_out[11:7];
  assign funct3    = instruction_mux_out[14:12];
  assign rs1_addr  = instruction_mux_out[19:15];
  assign rs2_addr  = instruction_mux_out[24:20];
  assign funct7_b5 = instruction_mux_out[30];

  assign imm_i = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:20]};
  assign imm_s = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:25],
                  instruction_mux_out[11:7]};
  assign imm_b = {{19{instruction_mux_out[31]}}, instruction_mux_out[31],
                  instruction_mux_out[7], instruction_mux_out[30:25],
                  instruction_mux_out[11:8], 1'b0};
  assign imm_u = {instruction_mux_out[31:12], 12'd0};
  assign imm_j = {{11{instruction_mux_out[31]}}, instruction_mux_out[31],
                  instruction_mux_out[19:12], instruction_mux_out[20],
                  instruction_mux_out[30:21], 1'b0};

  rv32i_regfile register_file (
    .clk (clk),
    .we  (reg_we),
    .ra1 (rs1_addr),
    .ra2 (rs2_addr),
    .wa  (rd_addr),
    .wd  (wb_data),
    .rd1 (rs1_val),
    .rd2 (rs2_val)
  );

  assign mux_a_out = (opcode == OP_AUIPC || opcode == OP_JAL || opcode == OP_BRANCH)
                     ? pc : rs1_val;

  always_comb begin
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: mux_b_out = imm_i;
      OP_STORE:                 mux_b_out = imm_s;
      OP_LUI, OP_AUIPC:         mux_b_out = imm_u;
      OP_JAL:                   mux_b_out = imm_j;
      default:                  mux_b_out = rs2_val;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_REG:  alu_sel = decode_alu(funct3, funct7_b5, 1'b1);
      OP_IMM:  alu_sel = decode_alu(funct3, funct7_b5, 1'b0);
      OP_LUI:  alu_sel = ALU_PASSB;
      default: alu_sel = ALU_ADD;
    endcase
  end

  assign alu_out = alu(alu_sel, mux_a_out, mux_b_out);

  // Branch decision uses the register operands directly, independent of the ALU.
  assign rs1_s = rs1_val;
  assign rs2_s = rs2_val;
  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = (rs1_s < rs2_s);
      3'b101:  br_taken = (rs1_s >= rs2_s);
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign mem_we = !reset && (opcode == OP_STORE);

  rv32i_dmem data_memory (
    .clk    (clk),
    .we     (mem_we),
    .widx   (alu_out[11:2]),
    .lane   (alu_out[1:0]),
    .funct3 (funct3),
    .wdata  (rs2_val),
    .rdata  (load_data)
  );

  always_comb begin
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: reg_we = !reset;
      default:                                                    reg_we = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    case (opcode)
      OP_JAL, OP_JALR: wb_data = pc_plus4;
      OP_LOAD:         wb_data = load_data;
      default:         wb_data = alu_out;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_JAL:    pc_in = alu_out;
      OP_JALR:   pc_in = {alu_out[31:1], 1'b0};
      OP_BRANCH: pc_in = br_taken ? (pc + imm_b) : pc_plus4;
      default:   pc_in = pc_plus4;
    endcase
  end

  // Architectural state boundary: PC commits with the register/memory writes.
  always_ff @(posedge clk) begin
    if (reset) pc <= 32'd0;
    else       pc <= pc_in;
  end

endmodule

// Instruction memory: 1024 x 32, combinational read. The write port is tied
// off inside the core; contents are normally preloaded from outside.
module rv32i_imem (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [9:0]  raddr,
  output logic [31:0] rdata
);
  logic [31:0] mem [0:1023];

  // Plain always: the array is also loaded hierarchically from outside.
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// Register file: two combinational read ports, one write port, x0 fixed at 0.
module rv32i_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regFile [0:31];

  always @(posedge clk) begin
    if (we && wa != 5'd0) regFile[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regFile[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regFile[ra2];
endmodule

// Data memory: 1024 x 32 with byte-lane stores and sign/zero-extending loads.
// Misaligned halfword/word accesses stay inside the aligned word.
module rv32i_dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  widx,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] mem [0:1023];
  logic [31:0] word;
  logic [31:0] wword;
  logic [3:0]  be;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign word = mem[widx];

  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    case (funct3)
      3'b000: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
      end
      3'b001: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_comb begin
    case (lane)
      2'd0:    rbyte = word[7:0];
      2'd1:    rbyte = word[15:8];
      2'd2:    rbyte = word[23:16];
      default: rbyte = word[31:24];
    endcase
  end

  assign rhalf = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (funct3)
      3'b000:  rdata = {{24{rbyte[7]}}, rbyte};
      3'b001:  rdata = {{16{rhalf[15]}}, rhalf};
      3'b100:  rdata = {24'd0, rbyte};
      3'b101:  rdata = {16'd0, rhalf};
      default: rdata = word;
    endcase
  end
endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: preloads memories and registers through the
// hierarchy, steps the core one edge at a time and checks architectural state.
module tb_rv32i_core;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rv32i_core dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2,
                                        logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2,
                                        logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;

    for (int i = 0; i < 1024; i++) begin
      dut.insn_memory.mem[i] = 32'd0;
      dut.data_memory.mem[i] = 32'd0;
    end
    for (int k = 0; k < 32; k++) dut.register_file.regFile[k] = k;

    dut.insn_memory.mem[0]  = enc_i(12'd50, 5'd1, 3'd0, 5'd1, 7'h13);   // ADDI x1,x1,50
    dut.insn_memory.mem[1]  = enc_i(12'd2, 5'd2, 3'd0, 5'd2, 7'h13);    // ADDI x2,x2,2
    dut.insn_memory.mem[2]  = 32'h4020A1B3;                             // SLT x3,x1,x2
    dut.insn_memory.mem[5]  = enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13);    // ADDI x0,x0,5
    dut.insn_memory.mem[6]  = enc_r(7'h20, 5'd6, 5'd5, 3'd0, 5'd10);    // SUB x10,x5,x6
    dut.insn_memory.mem[7]  = enc_r(7'h20, 5'd6, 5'd5, 3'd5, 5'd11);    // SRA x11,x5,x6
    dut.insn_memory.mem[8]  = enc_r(7'h00, 5'd6, 5'd5, 3'd3, 5'd12);    // SLTU x12,x5,x6
    dut.insn_memory.mem[9]  = enc_r(7'h00, 5'd8, 5'd7, 3'd0, 5'd13);    // ADD x13,x7,x8
    dut.insn_memory.mem[10] = enc_s(12'd0, 5'd14, 5'd0, 3'd2);          // SW x14,0(x0)
    dut.insn_memory.mem[11] = enc_i(12'd0, 5'd0, 3'd0, 5'd15, 7'h03);   // LB x15,0(x0)
    dut.insn_memory.mem[12] = enc_i(12'd1, 5'd0, 3'd0, 5'd16, 7'h03);   // LB x16,1(x0)
    dut.insn_memory.mem[13] = enc_i(12'd3, 5'd0, 3'd4, 5'd17, 7'h03);   // LBU x17,3(x0)
    dut.insn_memory.mem[14] = enc_i(12'd2, 5'd0, 3'd1, 5'd18, 7'h03);   // LH x18,2(x0)
    dut.insn_memory.mem[15] = enc_s(12'd1, 5'd19, 5'd0, 3'd0);          // SB x19,1(x0)
    dut.insn_memory.mem[16] = enc_i(12'd1, 5'd0, 3'd0, 5'd20, 7'h03);   // LB x20,1(x0)
    dut.insn_memory.mem[17] = enc_b(13'd16, 5'd1, 5'd1, 3'd0);          // BEQ x1,x1,+16
    dut.insn_memory.mem[18] = enc_i(12'd99, 5'd0, 3'd0, 5'd21, 7'h13);  // ADDI x21,x0,99 (skipped)
    dut.insn_memory.mem[21] = enc_b(13'd16, 5'd1, 5'd1, 3'd1);          // BNE x1,x1,+16
    dut.insn_memory.mem[22] = enc_j(21'd16, 5'd22);                     // JAL x22,+16
    dut.insn_memory.mem[26] = enc_i(12'd3, 5'd24, 3'd0, 5'd23, 7'h67);  // JALR x23,3(x24)
    dut.insn_memory.mem[50] = enc_i(12'd7, 5'd0, 3'd0, 5'd25, 7'h13);   // ADDI x25,x0,7
    dut.insn_memory.mem[51] = enc_i(12'd1, 5'd0, 3'd0, 5'd26, 7'h13);   // ADDI x26,x0,1

    // Reset edge
    step();
    check("reset_pc", dut.pc, 32'h0000_0000);
    check("reset_nop", dut.instruction_mux_out, 32'h0000_0013);
    check("reset_keeps_x1", dut.register_file.regFile[1], 32'd1);

    reset = 1'b0;
    #1;
    check("fetch_w0", dut.instruction_mux_out, 32'h0320_8093);
    check("mux_a_w0", dut.mux_a_out, 32'd1);
    check("mux_b_w0", dut.mux_b_out, 32'd50);
    check("alu_w0", dut.alu_out, 32'd51);
    check("pc_in_w0", dut.pc_in, 32'd4);

    step();
    check("addi_x1", dut.register_file.regFile[1], 32'd51);
    check("pc_after_1", dut.pc, 32'd4);
    step();
    check("addi_x2", dut.register_file.regFile[2], 32'd4);
    step();
    check("slt_f7_ignored_x3", dut.register_file.regFile[3], 32'd0);
    check("pc_after_3", dut.pc, 32'd12);

    // Zero words at 12 and 16 behave as NOPs
    step();
    check("nop_pc16", dut.pc, 32'd16);
    check("nop_x1", dut.register_file.regFile[1], 32'd51);
    check("nop_x3", dut.register_file.regFile[3], 32'd0);
    step();
    check("nop_pc20", dut.pc, 32'd20);

    dut.register_file.regFile[5]  = 32'hFFFF_FFF0;
    dut.register_file.regFile[6]  = 32'd4;
    dut.register_file.regFile[7]  = 32'hFFFF_FFFF;
    dut.register_file.regFile[8]  = 32'd1;
    dut.register_file.regFile[14] = 32'h80FF_7F01;
    dut.register_file.regFile[19] = 32'h0000_00AA;
    dut.register_file.regFile[24] = 32'd200;

    step();
    check("x0_stays_zero", dut.register_file.regFile[0], 32'd0);
    step();
    check("sub", dut.register_file.regFile[10], 32'hFFFF_FFEC);
    step();
    check("sra", dut.register_file.regFile[11], 32'hFFFF_FFFF);
    step();
    check("sltu", dut.register_file.regFile[12], 32'd0);
    step();
    check("add_wrap", dut.register_file.regFile[13], 32'd0);

    step();
    check("sw_word", dut.data_memory.mem[0], 32'h80FF_7F01);
    step();
    check("lb_0", dut.register_file.regFile[15], 32'h0000_0001);
    step();
    check("lb_1", dut.register_file.regFile[16], 32'h0000_007F);
    step();
    check("lbu_3", dut.register_file.regFile[17], 32'h0000_0080);
    step();
    check("lh_2", dut.register_file.regFile[18], 32'hFFFF_80FF);
    step();
    check("sb_1", dut.data_memory.mem[0], 32'h80FF_AA01);
    step();
    check("lb_1_neg", dut.register_file.regFile[20], 32'hFFFF_FFAA);
    check("pc_before_beq", dut.pc, 32'd68);

    step();
    check("beq_taken_pc", dut.pc, 32'd84);
    check("beq_skip_x21", dut.register_file.regFile[21], 32'd21);
    step();
    check("bne_not_taken_pc", dut.pc, 32'd88);
    step();
    check("jal_rd", dut.register_file.regFile[22], 32'd92);
    check("jal_pc", dut.pc, 32'd104);
    step();
    check("jalr_rd", dut.register_file.regFile[23], 32'd108);
    check("jalr_pc_bit0", dut.pc, 32'd202);
    check("fetch_ignores_pc_lsb", dut.instruction_mux_out,
          enc_i(12'd7, 5'd0, 3'd0, 5'd25, 7'h13));
    step();
    check("addi_x25", dut.register_file.regFile[25], 32'd7);
    check("pc_206", dut.pc, 32'd206);

    // Reset mid-run: the ADDI x26 at this edge must not commit
    reset = 1'b1;
    step();
    check("midrun_reset_pc", dut.pc, 32'd0);
    check("midrun_reset_x26", dut.register_file.regFile[26], 32'd26);
    check("midrun_reset_x25", dut.register_file.regFile[25], 32'd7);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_core.md
# rv32i_core

Single-cycle RV32I integer core: fetch, decode, execute, memory access and write-back all complete in one clock. It contains its own 1024-word instruction memory, 1024-word data memory, 32×32 register file and ALU. It is the top of the processor datapath; benches preload memories and registers hierarchically.

## Interface
- No parameters. Memory depth is fixed at 1024 words each; XLEN is 32.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- There are no other ports. Observation and preload go through fixed hierarchical names:
  - `pc`: current PC.
  - `pc_in`: next PC.
  - `instruction_mux_out`: executed instruction.
  - `mux_a_out` / `mux_b_out`: ALU operands.
  - `alu_out`: ALU result.
  - `register_file.regFile[0:31]`: register file.
  - `insn_memory.mem[0:1023]`: instruction memory.
  - `data_memory.mem[0:1023]`: data memory.

## Operation
- Fetch: `instruction = insn_memory.mem[pc[11:2]]`, combinational. `pc[1:0]` is ignored.
- Instruction mux: `instruction_mux_out` is 0x00000013 (NOP) while reset=1; otherwise it is the fetched word.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU; SB, SH, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Unsupported opcodes are NOPs: no register or memory write, next PC = PC+4. This covers FENCE, SYSTEM and the all-zero word.
- funct7[5] is decoded only for ADD/SUB and SRL/SRA (R-type) and SRLI/SRAI. It is ignored elsewhere, so 0x4020A1B3 executes as SLT x3,x1,x2.
- Immediates: I, S, B, U and J forms are sign-extended per the RV32I spec.
- Operand A mux (`mux_a_out`): PC for AUIPC, JAL and branch targets; otherwise rs1.
- Operand B mux (`mux_b_out`): immediate for I, S, U and J types; otherwise rs2.
- ALU:
  - Shift amount is `b[4:0]`.
  - SLT is signed and SLTU unsigned; the result is 0 or 1, zero-extended.
  - Arithmetic wraps modulo 2^32.
- Branches:
  - The comparison is done on rs1 and rs2, separate from the ALU sum.
  - Taken: next PC = PC + B-imm. Not taken: PC+4.
- JAL: rd = PC+4, next PC = PC + J-imm.
- JALR: rd = PC+4, next PC = (rs1 + I-imm) & ~1.
- Data memory:
  - Word index is `addr[11:2]`; byte lanes are selected by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - SB/SH update only the addressed lanes.
  - Misaligned halfword/word accesses use the aligned word with no trap.
- Register file:
  - Two combinational read ports and one write port.
  - x0 reads as 0 and writes to it are discarded.
  - Reset does not clear the register file or either memory.

## Timing
- Every instruction takes one cycle.
- PC, the register file and data memory all update on the same rising edge.
- Rising edge with reset=1:
  - PC ← 0.
  - No register or memory write.
- Rising edge with reset=0: PC ← `pc_in`, and the rd and store writes of the current instruction commit.
- Reset value: PC = 0x00000000. The register file and memories keep their contents.
- Reads are combinational. A register written at edge N is visible to the instruction executing after edge N, so there are no hazards.
- Reset asserted mid-program: at the next edge PC returns to 0, and the instruction current at that edge does not commit.
- PC wraps modulo 2^32. Fetch address wraps modulo 1024 words.

## Test plan
- Preload regFile[k]=k and load ADDI x1,x1,50 / ADDI x2,x2,2 / 0x4020A1B3 at words 0–2. Run three non-reset edges after PC=0. Required: x1=51, x2=4, x3=0, and PC=12 afterwards.
- Zero-word NOP: the all-zero word at address 12 leaves registers unchanged and PC advances by 4 per edge.
- Write to x0 (ADDI x0,x0,5): x0 still reads 0.
- SUB/SRA/SLTU:
  - x5=0xFFFFFFF0, x6=4.
  - Required: SUB gives 0xFFFFFFEC, SRA gives 0xFFFFFFFF, SLTU x5,x6 gives 0.
  - ADD 0xFFFFFFFF+1 wraps to 0.
- Load/store:
  - SW 0x80FF7F01 to address 0, then LB at 0 returns 0x00000001 and LB at 1 returns 0x0000007F.
  - LBU at 3 returns 0x80, LH at 2 returns 0xFFFF80FF.
  - SB 0xAA at 1 leaves the other bytes intact.
- Control flow and reset:
  - BEQ taken: PC = PC + imm. BNE not taken: PC+4.
  - JAL: rd=PC+4.
  - JALR with odd target clears bit 0.
  - Assert reset mid-run: PC=0 after the edge and registers are unchanged.
